// File: rtl/cov_acc_2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cov_acc_2_pkg
// Description : Q16.16 constants, saturation helper and FSM encoding shared
//               by the innovation-covariance accumulator.
// Revision    : 1.0
// ============================================================================
package cov_acc_2_pkg;

    localparam int FRAC_BITS = 16;
    localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

    localparam logic [0:0] ACC   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    function automatic logic signed [31:0] sat32(input logic signed [63:0] x);
        logic signed [31:0] r;
        if (x > 64'sh0000_0000_7FFF_FFFF)
            r = SAT_MAX;
        else if (x < 64'shFFFF_FFFF_8000_0000)
            r = SAT_MIN;
        else
            r = x[31:0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cov_acc_2_mul_q16_sat.sv
`default_nettype none
// ============================================================================
// Module      : mul_q16_sat
// Description : Registered signed Q16.16 multiply, floor-shifted and
//               saturated back to 32 bits.
// Revision    : 1.0
// ============================================================================
module mul_q16_sat
    import cov_acc_2_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic signed [31:0] i_a,
    input  logic signed [31:0] i_b,
    output logic signed [31:0] o_p
);

    logic signed [63:0] w_prod;
    logic signed [63:0] w_shift;

    assign w_prod  = 64'(i_a) * 64'(i_b);
    assign w_shift = w_prod >>> FRAC_BITS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_p <= '0;
        else if (clk_en)
            o_p <= sat32(w_shift);
    end

endmodule
`default_nettype wire

// File: rtl/cov_acc_2.sv
`default_nettype none
// ============================================================================
// Module      : cov_acc_2
// Description : Accumulates S = sum(w_i * d_i * d_i^T) + R over N_POINTS
//               sigma points and emits {S22, S21, S11} with a valid pulse.
// Revision    : 1.0
// ============================================================================
module cov_acc_2
    import cov_acc_2_pkg::*;
#(
    parameter int N_POINTS = 13,
    parameter int ACC_W    = 40
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [63:0] dev,
    input  logic [31:0] w,
    input  logic        dev_valid,
    output logic        dev_ready,
    input  logic [95:0] R,
    output logic [95:0] S,
    output logic        S_valid
);

    localparam logic [7:0] C_CNT_LAST = 8'(N_POINTS - 1);

    logic               w_accept;
    logic               w_out;
    logic signed [31:0] w_s1_a [3];
    logic signed [31:0] w_s1_b [3];
    logic signed [31:0] w_p    [3];
    logic signed [31:0] w_q    [3];
    logic        [31:0] w_s    [3];

    logic signed [31:0] r_w;
    logic               r_v1;
    logic               r_v2;
    logic        [95:0] r_r;
    logic        [7:0]  r_cnt;
    logic        [1:0]  r_flush_cnt;
    logic        [0:0]  r_state;

    assign w_accept = clk_en && dev_valid && dev_ready;
    // The last sample lands in the accumulators on the second FLUSH edge.
    assign w_out    = (r_state == FLUSH) && (r_flush_cnt == 2'd2);

    assign w_s1_a[0] = dev[31:0];
    assign w_s1_b[0] = dev[31:0];
    assign w_s1_a[1] = dev[63:32];
    assign w_s1_b[1] = dev[31:0];
    assign w_s1_a[2] = dev[63:32];
    assign w_s1_b[2] = dev[63:32];

    assign S = {w_s[2], w_s[1], w_s[0]};

    generate
        for (genvar g = 0; g < 3; g++) begin : g_elem
            logic signed [ACC_W-1:0] r_acc;
            logic        [31:0]      r_s;
            logic signed [ACC_W-1:0] w_q_ext;
            logic signed [63:0]      w_sum;

            mul_q16_sat u_mul_dd (
                .clk    (clk),
                .rst_n  (rst_n),
                .clk_en (clk_en),
                .i_a    (w_s1_a[g]),
                .i_b    (w_s1_b[g]),
                .o_p    (w_p[g])
            );

            mul_q16_sat u_mul_w (
                .clk    (clk),
                .rst_n  (rst_n),
                .clk_en (clk_en),
                .i_a    (w_p[g]),
                .i_b    (r_w),
                .o_p    (w_q[g])
            );

            assign w_q_ext = {{(ACC_W-32){w_q[g][31]}}, w_q[g]};
            assign w_sum   = {{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc}
                           + {{32{r_r[32*g+31]}}, r_r[32*g +: 32]};
            assign w_s[g]  = r_s;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc <= '0;
                    r_s   <= '0;
                end else if (clk_en) begin
                    if (w_out) begin
                        r_acc <= '0;
                        r_s   <= sat32(w_sum);
                    end else if (r_v2) begin
                        r_acc <= r_acc + w_q_ext;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_cnt       <= '0;
            r_flush_cnt <= '0;
            r_r         <= '0;
            r_w         <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            dev_ready   <= 1'b1;
            S_valid     <= 1'b0;
        end else if (clk_en) begin
            r_v1    <= w_accept;
            r_v2    <= r_v1;
            r_w     <= w;
            S_valid <= 1'b0;
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        if (r_cnt == C_CNT_LAST) begin
                            r_cnt       <= '0;
                            r_flush_cnt <= '0;
                            r_r         <= R;
                            r_state     <= FLUSH;
                            dev_ready   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (w_out) begin
                        r_state   <= ACC;
                        dev_ready <= 1'b1;
                        S_valid   <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 2'd1;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cov_acc_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_cov_acc_2
// Description : Self-checking bench for cov_acc_2 against a window-level
//               arithmetic model of the covariance sum.
// Revision    : 1.0
// ============================================================================
module tb_cov_acc_2;

    localparam int NP = 3;
    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] MONE = 32'hFFFF_0000;
    localparam logic [31:0] TWO  = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_en = 1'b0;
    logic [63:0] dev = '0;
    logic [31:0] w = '0;
    logic        dev_valid = 1'b0;
    logic        dev_ready;
    logic [95:0] R = '0;
    logic [95:0] S;
    logic        S_valid;

    cov_acc_2 #(.N_POINTS(NP), .ACC_W(40)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .dev       (dev),
        .w         (w),
        .dev_valid (dev_valid),
        .dev_ready (dev_ready),
        .R         (R),
        .S         (S),
        .S_valid   (S_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: samples of the open window, latched R, ready and output state.
    longint      q_d1[$], q_d2[$], q_w[$];
    bit          m_ready = 1'b1;
    bit          m_sv = 1'b0;
    int          m_cnt = 0;
    int          m_left = 0;
    logic [95:0] m_S = '0;
    logic [95:0] m_R = '0;
    bit          tog_ph = 1'b0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic longint sat(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic longint qmul(input longint a, input longint b);
        return sat((a * b) >>> 16);
    endfunction

    function automatic logic [95:0] model_S();
        logic [95:0] r;
        logic [31:0] rs;
        longint acc, x, y, rr;
        r = '0;
        for (int e = 0; e < 3; e++) begin
            acc = 0;
            for (int i = 0; i < q_d1.size(); i++) begin
                x = (e == 0) ? q_d1[i] : q_d2[i];
                y = (e == 2) ? q_d2[i] : q_d1[i];
                acc += qmul(qmul(x, y), q_w[i]);
            end
            rs = m_R[32*e +: 32];
            rr = longint'($signed(rs));
            r[32*e +: 32] = 32'(sat(acc + rr));
        end
        return r;
    endfunction

    task automatic step(input bit en, input bit vld, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] ww, output bit acc);
        bit nsv;
        clk_en = en; dev_valid = vld; dev = {a2, a1}; w = ww;
        @(posedge clk);
        acc = 1'b0;
        if (en) begin
            nsv = 1'b0;
            if (!m_ready) begin
                if (m_left == 1) begin
                    nsv = 1'b1;
                    m_S = model_S();
                    m_ready = 1'b1;
                    q_d1.delete(); q_d2.delete(); q_w.delete();
                end else begin
                    m_left--;
                end
            end else if (vld) begin
                acc = 1'b1;
                q_d1.push_back(longint'($signed(a1)));
                q_d2.push_back(longint'($signed(a2)));
                q_w.push_back(longint'($signed(ww)));
                m_cnt++;
                if (m_cnt == NP) begin
                    m_ready = 1'b0; m_left = 3; m_cnt = 0; m_R = R;
                end
            end
            m_sv = nsv;
        end
        @(negedge clk);
        check("dev_ready", {95'd0, dev_ready}, {95'd0, m_ready});
        check("S_valid", {95'd0, S_valid}, {95'd0, m_sv});
        check("S", S, m_S);
    endtask

    task automatic send(input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] ww, input bit toggle);
        bit a = 1'b0;
        bit en;
        int k = 0;
        while (!a && k < 40) begin
            en = toggle ? tog_ph : 1'b1;
            tog_ph = ~tog_ph;
            step(en, 1'b1, a1, a2, ww, a);
            k++;
        end
        if (!a) check("send_timeout", 96'd0, 96'd1);
    endtask

    task automatic drain(input bit toggle, input bit hold_valid, output int edges);
        bit a, en;
        int k = 0;
        edges = 0;
        while (!m_sv && k < 40) begin
            en = toggle ? tog_ph : 1'b1;
            tog_ph = ~tog_ph;
            step(en, hold_valid, 32'h1234_0000, 32'h0567_0000, ONE, a);
            if (en) edges++;
            k++;
        end
        if (!m_sv) check("drain_timeout", 96'd0, 96'd1);
        step(1'b1, 1'b0, '0, '0, '0, a);
    endtask

    // Called right after a falling edge; reset is asserted and released away from rising edges.
    task automatic do_reset();
        dev_valid = 1'b0; clk_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_S", S, 96'd0);
        check("rst_S_valid", {95'd0, S_valid}, 96'd0);
        check("rst_ready", {95'd0, dev_ready}, 96'd1);
        q_d1.delete(); q_d2.delete(); q_w.delete();
        m_ready = 1'b1; m_sv = 1'b0; m_cnt = 0; m_left = 0; m_S = '0; m_R = '0;
        #9 rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_q();
        if ($urandom_range(0, 4) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
    endfunction

    initial begin
        int edges;
        bit a;
        @(negedge clk);
        do_reset();

        // Identity-like window, full enable.
        R = '0;
        send(ONE, 32'd0, ONE, 1'b0);
        send(32'd0, ONE, ONE, 1'b0);
        send(ONE, ONE, ONE, 1'b0);
        drain(1'b0, 1'b0, edges);
        check("t1_latency", 96'(edges), 96'd3);
        check("t1_S", S, {TWO, ONE, TWO});

        // Zero deviations: S reduces to R.
        R = {32'h02ee_0000, 32'h00fa_0000, 32'h03e8_0000};
        repeat (NP) send(32'd0, 32'd0, ONE, 1'b0);
        drain(1'b0, 1'b0, edges);
        check("t2_S_eq_R", S, {32'h02ee_0000, 32'h00fa_0000, 32'h03e8_0000});
        R = '0;

        // Negative weight.
        send(TWO, 32'd0, MONE, 1'b0);
        send(ONE, 32'd0, ONE, 1'b0);
        send(32'd0, ONE, ONE, 1'b0);
        drain(1'b0, 1'b0, edges);
        check("t3_S_negw", S, {ONE, 32'd0, 32'hFFFD_0000});

        // Saturation of the d1*d1 path.
        repeat (NP) send(32'h7FFF_0000, 32'd0, ONE, 1'b0);
        drain(1'b0, 1'b0, edges);
        check("t4_S_sat", S, {32'd0, 32'd0, 32'h7FFF_FFFF});

        // Toggling enable with dev_valid held through the flush.
        tog_ph = 1'b0;
        send(ONE, 32'd0, ONE, 1'b1);
        send(32'd0, ONE, ONE, 1'b1);
        send(ONE, ONE, ONE, 1'b1);
        drain(1'b1, 1'b1, edges);
        check("t5_latency_en", 96'(edges), 96'd3);
        check("t5_S", S, {TWO, ONE, TWO});

        // Reset in the middle of a window.
        send(32'h0005_0000, 32'h0003_0000, ONE, 1'b0);
        send(32'h0002_0000, 32'h0007_0000, ONE, 1'b0);
        do_reset();
        send(ONE, 32'd0, ONE, 1'b0);
        send(32'd0, ONE, ONE, 1'b0);
        send(ONE, ONE, ONE, 1'b0);
        drain(1'b0, 1'b0, edges);
        check("t6_S_after_rst", S, {TWO, ONE, TWO});

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 9) == 0) R = {rnd_q(), rnd_q(), rnd_q()};
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 rnd_q(), rnd_q(), 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
